// File: rtl/picomips_pkg.sv
// Shared types and helpers for the parametrised picoMips accumulator core.
package picomips_pkg;

  localparam int OPC_W = 4;

  typedef enum logic [OPC_W-1:0] {
    OP_NOP   = 4'h0,
    OP_LDI   = 4'h1,
    OP_LDSW  = 4'h2,
    OP_LDR   = 4'h3,
    OP_STR   = 4'h4,
    OP_ADDI  = 4'h5,
    OP_ADDR  = 4'h6,
    OP_MULI  = 4'h7,
    OP_MULR  = 4'h8,
    OP_JMP   = 4'h9,
    OP_BZ    = 4'hA,
    OP_BN    = 4'hB,
    OP_WAIT  = 4'hC,
    OP_HALT  = 4'hD,
    OP_RSV_E = 4'hE,
    OP_RSV_F = 4'hF
  } opcode_t;

  typedef enum logic [2:0] {
    FETCH,
    DECODE,
    EXEC,
    WAIT_HI,
    WAIT_LO,
    HALT
  } state_t;

  // Q1.(w-1) fractional product of two w-bit values sign-extended to 16 bits.
  function automatic logic [15:0] frac_mul(input logic signed [15:0] a,
                                           input logic signed [15:0] b,
                                           input int unsigned w);
    logic signed [31:0] p;
    p = $signed({{16{a[15]}}, a}) * $signed({{16{b[15]}}, b});
    return 16'(p >>> (w - 1));
  endfunction

endpackage

// File: rtl/picomips_regfile.sv
// NREG x DATA_W register file: async-reset flops, one write port, one combinational read port.
module picomips_regfile
  import picomips_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int NREG   = 2,
  localparam int REG_AW = (NREG > 2) ? $clog2(NREG) : 1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_we,
  input  logic [REG_AW-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [REG_AW-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [NREG];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_mem <= '{default: '0};
    end else if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/picomips_core_p.sv
// Multi-cycle (FETCH/DECODE/EXEC) accumulator core with branches, WAIT handshake and HALT.
// Define PICOMIPS_MUL_EN to build the fractional multiplier for MULI/MULR.
module picomips_core_p
  import picomips_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int NREG   = 2,
  parameter int PC_W   = 5,
  localparam int INSTR_W = DATA_W + OPC_W
) (
  input  logic               Clock,
  input  logic               nReset,
  output logic [PC_W-1:0]    instr_addr,
  input  logic [INSTR_W-1:0] instr_data,
  input  logic [DATA_W-1:0]  sw_in,
  input  logic               Handshake,
  output logic [DATA_W-1:0]  acc_out,
  output logic               waiting,
  output logic               halted
);

  localparam int REG_AW = (NREG > 2) ? $clog2(NREG) : 1;

  state_t             r_state;
  logic [PC_W-1:0]    r_pc;
  logic [DATA_W-1:0]  r_acc;
  logic [INSTR_W-1:0] r_ir;
  logic               r_waiting;
  logic               r_halted;
  logic               r_hs_meta;
  logic               r_hs_sync;

  opcode_t            w_op;
  logic [DATA_W-1:0]  w_field;
  logic [REG_AW-1:0]  w_reg;
  logic [PC_W-1:0]    w_target;
  logic [DATA_W-1:0]  w_rdata;
  logic               w_we;

  assign w_op     = opcode_t'(r_ir[INSTR_W-1 -: OPC_W]);
  assign w_field  = r_ir[DATA_W-1:0];
  assign w_reg    = w_field[REG_AW-1:0];
  assign w_target = w_field[PC_W-1:0];
  assign w_we     = (r_state == EXEC) && (w_op == OP_STR);

`ifdef PICOMIPS_MUL_EN
  logic [DATA_W-1:0] w_mul_b;
  logic [DATA_W-1:0] w_mul;
  assign w_mul_b = (w_op == OP_MULR) ? w_rdata : w_field;
  assign w_mul   = DATA_W'(frac_mul(16'(signed'(r_acc)), 16'(signed'(w_mul_b)), DATA_W));
`endif

  picomips_regfile #(
    .DATA_W (DATA_W),
    .NREG   (NREG)
  ) u_regfile (
    .i_clk   (Clock),
    .i_rst_n (nReset),
    .i_we    (w_we),
    .i_waddr (w_reg),
    .i_wdata (r_acc),
    .i_raddr (w_reg),
    .o_rdata (w_rdata)
  );

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      r_hs_meta <= 1'b0;
      r_hs_sync <= 1'b0;
    end else begin
      r_hs_meta <= Handshake;
      r_hs_sync <= r_hs_meta;
    end
  end

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      r_state   <= FETCH;
      r_pc      <= '0;
      r_acc     <= '0;
      r_ir      <= '0;
      r_waiting <= 1'b0;
      r_halted  <= 1'b0;
    end else begin
      case (r_state)
        FETCH:  r_state <= DECODE;
        DECODE: begin
          r_ir    <= instr_data;
          r_state <= EXEC;
        end
        EXEC: begin
          // Default sequential PC; branch/WAIT/HALT arms override it.
          r_pc    <= r_pc + 1'b1;
          r_state <= FETCH;
          case (w_op)
            OP_LDI:  r_acc <= w_field;
            OP_LDSW: r_acc <= sw_in;
            OP_LDR:  r_acc <= w_rdata;
            OP_ADDI: r_acc <= r_acc + w_field;
            OP_ADDR: r_acc <= r_acc + w_rdata;
`ifdef PICOMIPS_MUL_EN
            OP_MULI, OP_MULR: r_acc <= w_mul;
`endif
            OP_JMP:  r_pc <= w_target;
            OP_BZ:   if (r_acc == '0) r_pc <= w_target;
            OP_BN:   if (r_acc[DATA_W-1]) r_pc <= w_target;
            OP_WAIT: begin
              r_pc      <= r_pc;
              r_state   <= WAIT_HI;
              r_waiting <= 1'b1;
            end
            OP_HALT: begin
              r_pc     <= r_pc;
              r_state  <= HALT;
              r_halted <= 1'b1;
            end
            default: ;
          endcase
        end
        WAIT_HI: if (r_hs_sync) r_state <= WAIT_LO;
        WAIT_LO: begin
          if (!r_hs_sync) begin
            r_pc      <= r_pc + 1'b1;
            r_state   <= FETCH;
            r_waiting <= 1'b0;
          end
        end
        HALT:    ;
        default: r_state <= FETCH;
      endcase
    end
  end

  assign instr_addr = r_pc;
  assign acc_out    = r_acc;
  assign waiting    = r_waiting;
  assign halted     = r_halted;

endmodule

// File: tb/tb_picomips_core_p.sv
// Self-checking bench: ISA-level reference interpreter plus directed and random programs.
module tb_picomips_core_p;

  localparam int DW = 8;
  localparam int NR = 2;
  localparam int PW = 5;
  localparam int IW = DW + 4;
  localparam int NPC = 1 << PW;

  logic          clk;
  logic          nReset;
  logic [PW-1:0] instr_addr;
  logic [IW-1:0] instr_data;
  logic [DW-1:0] sw_in;
  logic          Handshake;
  logic [DW-1:0] acc_out;
  logic          waiting;
  logic          halted;

  logic [IW-1:0] rom [NPC];

  int n_checks = 0;
  int n_fail   = 0;

  int m_pc, m_acc, m_wait, m_halt;
  int m_r [NR];

  picomips_core_p #(
    .DATA_W (DW),
    .NREG   (NR),
    .PC_W   (PW)
  ) dut (
    .Clock      (clk),
    .nReset     (nReset),
    .instr_addr (instr_addr),
    .instr_data (instr_data),
    .sw_in      (sw_in),
    .Handshake  (Handshake),
    .acc_out    (acc_out),
    .waiting    (waiting),
    .halted     (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External program memory: one-cycle read latency.
  always @(posedge clk) instr_data <= rom[instr_addr];

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [IW-1:0] ins(input int op, input int f);
    return IW'(((op & 15) << DW) | (f & ((1 << DW) - 1)));
  endfunction

  function automatic int sx(input int v);
    return (v >= (1 << (DW - 1))) ? v - (1 << DW) : v;
  endfunction

  task automatic clear_rom();
    for (int i = 0; i < NPC; i++) rom[i] = ins(0, 0);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One architectural instruction of the reference machine.
  task automatic model_step();
    int op, f, npc, opnd;
    op   = int'(rom[m_pc]) >> DW;
    f    = int'(rom[m_pc]) & ((1 << DW) - 1);
    npc  = (m_pc + 1) % NPC;
    opnd = m_r[f % NR];
    case (op)
      1:  m_acc = f;
      2:  m_acc = int'(sw_in);
      3:  m_acc = opnd;
      4:  m_r[f % NR] = m_acc;
      5:  m_acc = (m_acc + f) % (1 << DW);
      6:  m_acc = (m_acc + opnd) % (1 << DW);
`ifdef PICOMIPS_MUL_EN
      7:  m_acc = ((sx(m_acc) * sx(f)) >>> (DW - 1)) & ((1 << DW) - 1);
      8:  m_acc = ((sx(m_acc) * sx(opnd)) >>> (DW - 1)) & ((1 << DW) - 1);
`endif
      9:  npc = f % NPC;
      10: if (m_acc == 0) npc = f % NPC;
      11: if (m_acc >= (1 << (DW - 1))) npc = f % NPC;
      12: begin npc = m_pc; m_wait = 1; end
      13: begin npc = m_pc; m_halt = 1; end
      default: ;
    endcase
    m_pc = npc;
  endtask

  task automatic step(input string tag);
    model_step();
    tick(3);
    check({tag, ".acc"}, int'(acc_out), m_acc);
    check({tag, ".pc"}, int'(instr_addr), m_pc);
    check({tag, ".wait"}, int'(waiting), m_wait);
    check({tag, ".halt"}, int'(halted), m_halt);
  endtask

  task automatic start();
    @(negedge clk) nReset = 1'b0;
    m_pc = 0; m_acc = 0; m_wait = 0; m_halt = 0;
    for (int i = 0; i < NR; i++) m_r[i] = 0;
    #2;
    check("rst.acc", int'(acc_out), 0);
    check("rst.pc", int'(instr_addr), 0);
    check("rst.wait", int'(waiting), 0);
    check("rst.halt", int'(halted), 0);
    @(negedge clk) nReset = 1'b1;
  endtask

  initial begin
    int const_acc;
    nReset    = 1'b0;
    sw_in     = '0;
    Handshake = 1'b0;
    clear_rom();
    tick(2);

    // Add wrap, STR/LDR, and reset in the middle of an EXEC
    clear_rom();
    rom[0] = ins(1, 'h05); rom[1] = ins(5, 'h7E); rom[2] = ins(4, 1);
    rom[3] = ins(1, 0);    rom[4] = ins(6, 1);    rom[5] = ins(3, 1);
    rom[6] = ins(13, 0);
    start();
    step("abort.ldi");
    tick(2);
    nReset = 1'b0;
    #1;
    check("abort.acc", int'(acc_out), 0);
    check("abort.pc", int'(instr_addr), 0);
    check("abort.wait", int'(waiting), 0);
    start();
    for (int i = 0; i < 7; i++) step("add");
    check("add.final", int'(acc_out), 'h83);

    // Fractional multiply
    clear_rom();
    rom[0] = ins(1, 'h40); rom[1] = ins(7, 'h40); rom[2] = ins(1, 'hC0);
    rom[3] = ins(7, 'h40); rom[4] = ins(1, 'h80); rom[5] = ins(7, 'h80);
    rom[6] = ins(4, 0);    rom[7] = ins(1, 'h40); rom[8] = ins(8, 0);
    rom[9] = ins(13, 0);
    start();
    step("mul"); step("mul");
`ifdef PICOMIPS_MUL_EN
    check("mul.pos", int'(acc_out), 'h20);
`else
    check("mul.pos", int'(acc_out), 'h40);
`endif
    step("mul"); step("mul");
`ifdef PICOMIPS_MUL_EN
    check("mul.neg", int'(acc_out), 'hE0);
`else
    check("mul.neg", int'(acc_out), 'hC0);
`endif
    for (int i = 0; i < 6; i++) step("mul");

    // Branches, PC wrap and HALT at address 10
    clear_rom();
    rom[0]  = ins(11, 20); rom[1]  = ins(9, 31);  rom[31] = ins(1, 'h80);
    rom[20] = ins(10, 10); rom[21] = ins(1, 0);   rom[22] = ins(10, 10);
    rom[10] = ins(13, 0);
    start();
    for (int i = 0; i < 8; i++) step("br");
    check("br.halt_at", int'(instr_addr), 10);

    // WAIT handshake
    clear_rom();
    rom[0] = ins(1, 'h11); rom[3] = ins(12, 0); rom[4] = ins(1, 'h22);
    rom[5] = ins(13, 0);
    start();
    for (int i = 0; i < 4; i++) step("hs");
    tick(20);
    check("hs.idle.wait", int'(waiting), 1);
    check("hs.idle.pc", int'(instr_addr), 3);
    Handshake = 1'b1;
    tick(5);
    check("hs.high.wait", int'(waiting), 1);
    Handshake = 1'b0;
    tick(3);
    check("hs.done.wait", int'(waiting), 0);
    check("hs.done.pc", int'(instr_addr), 4);
    m_wait = 0; m_pc = 4;
    step("hs"); step("hs");

    // HALT at 7 freezes the core until reset
    clear_rom();
    for (int i = 0; i < 7; i++) rom[i] = ins(5, 3 * i + 1);
    rom[7] = ins(13, 0);
    start();
    for (int i = 0; i < 8; i++) step("halt");
    const_acc = m_acc;
    for (int i = 0; i < 5; i++) begin
      tick(10);
      check("halt.hold.acc", int'(acc_out), const_acc);
      check("halt.hold.pc", int'(instr_addr), 7);
      check("halt.hold.flag", int'(halted), 1);
    end
    start();
    check("halt.rel.pc", int'(instr_addr), 0);
    step("halt.rerun");

    // Random programs without WAIT/HALT, random switch data
    for (int p = 0; p < 3; p++) begin
      for (int i = 0; i < NPC; i++) begin
        int op;
        op = $urandom_range(0, 13);
        if (op == 12) op = 14;
        if (op == 13) op = 15;
        rom[i] = ins(op, int'($urandom_range(0, (1 << DW) - 1)));
      end
      start();
      for (int s = 0; s < 60; s++) begin
        sw_in = DW'($urandom);
        step("rnd");
      end
    end

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule

// File: doc/picomips_core_p.md
Name: picomips_core_p

Overview:
- Parametrised multi-cycle accumulator core. Successor to the fixed 8-bit picoMips datapath.
- Generalised data width, register-file depth and program-counter width.
- Adds conditional branches, HALT and a synchronised two-phase handshake WAIT.
- Program memory sits outside the block. The core drives an address and receives the instruction one cycle later. A board-level top wraps the core with a ROM, switches and LEDs.

Parameters:
- DATA_W, 8: accumulator, register, immediate and switch width (4..16).
- NREG, 2: register-file entries (power of 2, >=2). REG_AW = clog2(NREG), minimum 1.
- PC_W, 5: instruction address width.
- INSTR_W, DATA_W+4 (derived): {opcode[3:0], field[DATA_W-1:0]}. PC_W <= DATA_W is required.

Ports:
- Clock  in  1  system clock, rising edge.
- nReset  in  1  asynchronous, active-low reset.
- instr_addr  out  PC_W  program memory address (equals PC).
- instr_data  in  INSTR_W  instruction, valid one cycle after instr_addr.
- sw_in  in  DATA_W  switch data operand.
- Handshake  in  1  asynchronous handshake input.
- acc_out  out  DATA_W  accumulator value.
- waiting  out  1  high while the core is in either WAIT state.
- halted  out  1  high after HALT executes.

Behaviour:
- Reset, asynchronous:
  - PC=0, ACC=0, all registers=0, IR=0, state=FETCH.
  - waiting=0, halted=0, synchroniser flops=0.
  - Asserting reset mid-instruction or mid-WAIT aborts it. No partial register write occurs.
- States and transitions:
  - FETCH: instr_addr=PC. Go to DECODE.
  - DECODE: latch IR<=instr_data. Go to EXEC.
  - EXEC: perform the operation, update PC, go to FETCH. WAIT goes to WAIT_HI instead; HALT goes to HALT instead.
  - WAIT_HI: hold until hs_sync=1, then go to WAIT_LO.
  - WAIT_LO: hold until hs_sync=0, then PC<=PC+1 and go to FETCH.
  - HALT: terminal state until reset.
- Throughput: 3 cycles per instruction. ACC and register updates are visible on the EXEC clock edge.
- Operand fields: imm = field. reg = field[REG_AW-1:0]. target = field[PC_W-1:0].
- Opcodes:
  - 0 NOP.
  - 1 LDI: ACC=imm.
  - 2 LDSW: ACC=sw_in, sampled in EXEC.
  - 3 LDR: ACC=R[reg].
  - 4 STR: R[reg]=ACC.
  - 5 ADDI: ACC=ACC+imm.
  - 6 ADDR: ACC=ACC+R[reg].
  - 7 MULI.
  - 8 MULR.
  - 9 JMP: PC=target.
  - A BZ: branch if ACC==0.
  - B BN: branch if ACC[DATA_W-1].
  - C WAIT.
  - D HALT.
  - E, F reserved; execute as NOP.
- Arithmetic:
  - Add is signed two's complement, wraps modulo 2^DATA_W, no saturation, no flags.
  - MUL: full signed product P[2*DATA_W-1:0]. ACC=P[2*DATA_W-2 -: DATA_W] (Q1.(DATA_W-1) fractional). (-1)*(-1) yields the wrapped value 0x80 at DATA_W=8.
- PC:
  - Non-branch instructions: PC+1, wrapping from 2^PC_W-1 to 0.
  - A branch not taken is PC+1.
- Handshake:
  - Passes through a 2-flop synchroniser to give hs_sync.
  - A WAIT needs a full high-then-low pulse observed after entering WAIT_HI.
  - A level already high at entry counts as the high phase.
- Outputs:
  - waiting=1 exactly in WAIT_HI/WAIT_LO.
  - halted=1 from the HALT state onward.
  - In HALT, instr_addr holds PC of the HALT instruction and ACC is frozen.
- Register reads are combinational from the register file. STR followed immediately by LDR of the same register returns the new value, because each instruction spans 3 cycles.

Optional Feature:
- Macro PICOMIPS_MUL_EN.
- Defined: MULI/MULR implemented as above.
- Undefined: no multiplier is synthesised. Opcodes 7/8 execute as NOP (ACC unchanged, PC+1).

Decomposition:
- Package picomips_pkg holds:
  - opcode_t enum (4-bit, values above).
  - state_t enum (FETCH, DECODE, EXEC, WAIT_HI, WAIT_LO, HALT).
  - OPC_W=4 constant.
  - Function frac_mul(a, b, w) returning the truncated product slice.
- Sub-module picomips_regfile:
  - NREG x DATA_W.
  - Async-reset flops, one write port, one combinational read port.
  - Parametrised by DATA_W and NREG.

Test Plan (DATA_W=8, NREG=2, PC_W=5):
- Reset: nReset=0 during an EXEC of ADDI → same cycle gives acc_out=0x00, instr_addr=0, waiting=0. Release → first FETCH at address 0.
- Add wrap: LDI 0x05; ADDI 0x7E → acc_out=0x83 at cycle 6. STR r1; LDI 0; ADDR r1 → acc_out=0x83.
- Multiply: LDI 0x40; MULI 0x40 → acc_out=0x20. LDI 0xC0; MULI 0x40 → 0xE0. With PICOMIPS_MUL_EN undefined → acc_out stays 0x40 / 0xC0.
- Handshake: WAIT at addr 3, Handshake=0 for 20 cycles → waiting=1, instr_addr=3. Raise for 5 cycles, drop → waiting=0 within 3 cycles of the drop; next FETCH at addr 4.
- Branches: JMP 31; NOP at 31 → next fetch address 0. With ACC=0, BZ 10 → addr 10. With ACC=0x80, BZ 10 → addr+1 and BN 12 → addr 12.
- Halt: HALT at addr 7 → halted=1, instr_addr=7 and acc_out constant for 50 cycles. Pulse nReset → halted=0, fetch at addr 0.
